// File: rtl/av2_dbf_pkg.sv
// Shared types and helpers for the AV2 narrow deblocking edge filter.
// Holds the pipeline depth, the signed clamp and the threshold scaling.
package av2_dbf_pkg;

  localparam int DBF_PIPE_DEPTH = 3;
  localparam int DBF_W = 16;

  typedef logic signed [DBF_W-1:0] dbf_s_t;
  typedef logic [DBF_W-1:0] dbf_u_t;

  function automatic int dbf_idx(int lane, int tap, int bd);
    return (lane * 2 + tap) * bd;
  endfunction

  function automatic dbf_s_t dbf_clamp(dbf_s_t x, int bd);
    dbf_s_t hi;
    dbf_s_t lo;
    hi = dbf_s_t'((1 << (bd - 1)) - 1);
    lo = -hi - dbf_s_t'(1);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic dbf_u_t dbf_scale(logic [7:0] t, int bd);
    return dbf_u_t'(t) << (bd - 8);
  endfunction

endpackage

// File: rtl/av2_dbf_lane.sv
// Single-lane filter4 datapath: S1 abs diffs, S2 mask/hev/f, S3 outputs.
// Data registers carry no reset; validity is tracked by the top level.
module av2_dbf_lane
  import av2_dbf_pkg::*;
#(
  parameter int BIT_DEPTH = 10
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [BIT_DEPTH-1:0] p0,
  input  logic [BIT_DEPTH-1:0] p1,
  input  logic [BIT_DEPTH-1:0] q0,
  input  logic [BIT_DEPTH-1:0] q1,
  input  dbf_u_t               lim,
  input  dbf_u_t               blim,
  input  dbf_u_t               thr,
  output logic                 mask,
  output logic [BIT_DEPTH-1:0] op0,
  output logic [BIT_DEPTH-1:0] op1,
  output logic [BIT_DEPTH-1:0] oq0,
  output logic [BIT_DEPTH-1:0] oq1
);

  typedef logic [BIT_DEPTH-1:0] smp_t;

  localparam dbf_s_t OFF = dbf_s_t'(1 << (BIT_DEPTH - 1));

  function automatic dbf_u_t adiff(smp_t a, smp_t b);
    return (a > b) ? dbf_u_t'(a - b) : dbf_u_t'(b - a);
  endfunction

  function automatic dbf_s_t sgn(smp_t a);
    return dbf_s_t'(a) - OFF;
  endfunction

  smp_t   s1_p0, s1_p1, s1_q0, s1_q1;
  dbf_u_t s1_dp, s1_dq, s1_d0, s1_d1;

  always_ff @(posedge clk) begin
    if (en) begin
      s1_p0 <= p0;
      s1_p1 <= p1;
      s1_q0 <= q0;
      s1_q1 <= q1;
      s1_dp <= adiff(p1, p0);
      s1_dq <= adiff(q1, q0);
      s1_d0 <= adiff(p0, q0);
      s1_d1 <= adiff(p1, q1);
    end
  end

  dbf_s_t ps0, ps1, qs0, qs1;
  dbf_s_t fa, fb;
  logic   mask_c, hev_c;

  always_comb begin
    ps0    = sgn(s1_p0);
    ps1    = sgn(s1_p1);
    qs0    = sgn(s1_q0);
    qs1    = sgn(s1_q1);
    mask_c = (s1_dp <= lim) && (s1_dq <= lim) &&
             (((s1_d0 << 1) + (s1_d1 >> 1)) <= blim);
    hev_c  = (s1_dp > thr) || (s1_dq > thr);
    fa     = hev_c ? dbf_clamp(ps1 - qs1, BIT_DEPTH) : '0;
    fb     = mask_c ?
             dbf_clamp(fa + (qs0 - ps0) * dbf_s_t'(3), BIT_DEPTH) : '0;
  end

  logic   s2_mask, s2_hev;
  dbf_s_t s2_f, s2_ps0, s2_ps1, s2_qs0, s2_qs1;

  always_ff @(posedge clk) begin
    if (en) begin
      s2_mask <= mask_c;
      s2_hev  <= hev_c;
      s2_f    <= fb;
      s2_ps0  <= ps0;
      s2_ps1  <= ps1;
      s2_qs0  <= qs0;
      s2_qs1  <= qs1;
    end
  end

  assign mask = s2_mask;

  dbf_s_t f1, f2, g;

  // mask=0 forces f=0, which makes f1, f2 and g all zero: bit-exact pass
  always_comb begin
    f1 = dbf_clamp(s2_f + dbf_s_t'(4), BIT_DEPTH) >>> 3;
    f2 = dbf_clamp(s2_f + dbf_s_t'(3), BIT_DEPTH) >>> 3;
    g  = s2_hev ? '0 : (f1 + dbf_s_t'(1)) >>> 1;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      oq0 <= BIT_DEPTH'(dbf_clamp(s2_qs0 - f1, BIT_DEPTH) + OFF);
      op0 <= BIT_DEPTH'(dbf_clamp(s2_ps0 + f2, BIT_DEPTH) + OFF);
      oq1 <= BIT_DEPTH'(dbf_clamp(s2_qs1 - g, BIT_DEPTH) + OFF);
      op1 <= BIT_DEPTH'(dbf_clamp(s2_ps1 + g, BIT_DEPTH) + OFF);
    end
  end

endmodule

// File: rtl/av2_dbf_edge_stream.sv
// Streaming AV2 deblock edge filter: handshake, config latch, framing.
// Define AV2_DBF_STATS_EN to enable the per-segment mask_count counter.
module av2_dbf_edge_stream
  import av2_dbf_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int BIT_DEPTH = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic [7:0]                   cfg_limit,
  input  logic [7:0]                   cfg_blimit,
  input  logic [7:0]                   cfg_thresh,
  input  logic [LANES*2*BIT_DEPTH-1:0] in_p,
  input  logic [LANES*2*BIT_DEPTH-1:0] in_q,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*2*BIT_DEPTH-1:0] out_p,
  output logic [LANES*2*BIT_DEPTH-1:0] out_q,
  output logic                         out_last,
  output logic                         seg_done,
  output logic [31:0]                  mask_count
);

  localparam int D = DBF_PIPE_DEPTH;

  logic         stall, en, acc;
  logic [D-1:0] vld, lst;
  logic [7:0]   lim_q, blim_q, thr_q;
  logic [7:0]   lim_s, blim_s, thr_s;
  dbf_u_t       th_l, th_b, th_t;

  assign stall     = out_valid & ~out_ready;
  assign en        = ~stall;
  assign in_ready  = en;
  assign acc       = in_valid & in_ready;
  assign out_valid = vld[D-1];
  assign out_last  = lst[D-1];
  assign seg_done  = out_valid & out_ready & out_last;

  // a first beat is filtered with its own freshly presented config
  assign lim_s  = in_first ? cfg_limit  : lim_q;
  assign blim_s = in_first ? cfg_blimit : blim_q;
  assign thr_s  = in_first ? cfg_thresh : thr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= '0;
      lst    <= '0;
      lim_q  <= '0;
      blim_q <= '0;
      thr_q  <= '0;
    end else begin
      if (en) begin
        vld <= {vld[D-2:0], acc};
        lst <= {lst[D-2:0], acc & in_last};
      end
      if (acc && in_first) begin
        lim_q  <= cfg_limit;
        blim_q <= cfg_blimit;
        thr_q  <= cfg_thresh;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      th_l <= dbf_scale(lim_s, BIT_DEPTH);
      th_b <= dbf_scale(blim_s, BIT_DEPTH);
      th_t <= dbf_scale(thr_s, BIT_DEPTH);
    end
  end

`ifdef AV2_DBF_STATS_EN
  logic [LANES-1:0] lane_mask;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    av2_dbf_lane #(
      .BIT_DEPTH(BIT_DEPTH)
    ) u_lane (
      .clk (clk),
      .en  (en),
      .p0  (in_p[dbf_idx(i, 0, BIT_DEPTH) +: BIT_DEPTH]),
      .p1  (in_p[dbf_idx(i, 1, BIT_DEPTH) +: BIT_DEPTH]),
      .q0  (in_q[dbf_idx(i, 0, BIT_DEPTH) +: BIT_DEPTH]),
      .q1  (in_q[dbf_idx(i, 1, BIT_DEPTH) +: BIT_DEPTH]),
      .lim (th_l),
      .blim(th_b),
      .thr (th_t),
`ifdef AV2_DBF_STATS_EN
      .mask(lane_mask[i]),
`else
      .mask(),
`endif
      .op0 (out_p[dbf_idx(i, 0, BIT_DEPTH) +: BIT_DEPTH]),
      .op1 (out_p[dbf_idx(i, 1, BIT_DEPTH) +: BIT_DEPTH]),
      .oq0 (out_q[dbf_idx(i, 0, BIT_DEPTH) +: BIT_DEPTH]),
      .oq1 (out_q[dbf_idx(i, 1, BIT_DEPTH) +: BIT_DEPTH])
    );
  end

`ifdef AV2_DBF_STATS_EN
  logic [1:0]  fst;
  logic [31:0] pop;
  logic [32:0] sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + {31'b0, lane_mask[i]};
    end
    sum = {1'b0, mask_count} + {1'b0, pop};
  end

  // counts beats leaving S2; a first beat restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fst        <= '0;
      mask_count <= '0;
    end else if (en) begin
      fst <= {fst[0], acc & in_first};
      if (vld[1]) begin
        mask_count <= fst[1] ? pop : (sum[32] ? '1 : sum[31:0]);
      end
    end
  end
`else
  assign mask_count = '0;
`endif

endmodule
